// File: rtl/race_official_multi.sv
// Multi-lane race official: broadcasts start once all enabled lanes are ready,
// tracks finishers, picks the lowest-index first finisher, and aborts on timeout.
module race_official_multi #(
  parameter int N_LANES = 4,
  parameter int TIMEOUT = 1000,
  localparam int WIN_W = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LANES-1:0] lane_en,
  input  logic [N_LANES-1:0] ready,
  input  logic [N_LANES-1:0] done,
  output logic               start,
  output logic               busy,
  output logic [N_LANES-1:0] finished,
  output logic [WIN_W-1:0]   winner,
  output logic               winner_valid,
  output logic               timeout
);

  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RACE    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]         r_state;
  logic [N_LANES-1:0] r_en_q;
  logic [TMR_W-1:0]   r_timer;
  logic               r_start;
  logic [N_LANES-1:0] r_finished;
  logic [WIN_W-1:0]   r_winner;
  logic               r_winner_valid;
  logic               r_timeout;

  logic [N_LANES-1:0] w_nd;
  logic [WIN_W-1:0]   w_nd_idx;
  logic               w_arm;
  logic               w_all_done;
  logic               w_timer_hit;
  logic               w_released;

  // New finishers this cycle: enabled lanes reporting done for the first time.
  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_nd
    assign w_nd[gi] = done[gi] & r_en_q[gi] & ~r_finished[gi];
  end

  always_comb begin
    w_nd_idx = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (w_nd[i]) w_nd_idx = WIN_W'(i);
    end
  end

  assign w_arm       = (lane_en != '0) && ((ready & lane_en) == lane_en);
  assign w_all_done  = ((r_finished | w_nd) == r_en_q);
  assign w_timer_hit = (TIMEOUT != 0) && (r_timer == TMR_LAST);
  assign w_released  = (((ready | done) & r_en_q) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_en_q         <= '0;
      r_timer        <= '0;
      r_start        <= 1'b0;
      r_finished     <= '0;
      r_winner       <= '0;
      r_winner_valid <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_start <= 1'b0;
          if (w_arm) begin
            r_en_q         <= lane_en;
            r_start        <= 1'b1;
            r_timer        <= '0;
            r_finished     <= '0;
            r_winner_valid <= 1'b0;
            r_timeout      <= 1'b0;
            r_state        <= S_RACE;
          end
        end
        S_RACE: begin
          if (r_timer != TMR_MAX) r_timer <= r_timer + 1'b1;
          r_finished <= r_finished | w_nd;
          if (!r_winner_valid && (w_nd != '0)) begin
            r_winner       <= w_nd_idx;
            r_winner_valid <= 1'b1;
          end
          // Completion wins over a timeout landing on the same edge.
          if (w_all_done) begin
            r_start <= 1'b0;
            r_state <= S_RELEASE;
          end else if (w_timer_hit) begin
            r_start   <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          r_start <= 1'b0;
          if (w_released) r_state <= S_IDLE;
        end
        default: begin
          r_start <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign start        = r_start;
  assign busy         = (r_state != S_IDLE);
  assign finished     = r_finished;
  assign winner       = r_winner;
  assign winner_valid = r_winner_valid;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_race_official_multi.sv
// Bench for race_official_multi: directed vector table, async-reset sequence,
// and randomized traffic checked against a finish-time based reference model.
module tb_race_official_multi;

  localparam int N  = 4;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] lane_en, ready, done;
  logic       start, busy, winner_valid, timeout;
  logic [3:0] finished;
  logic [1:0] winner;

  int n_vec = 0;
  int n_err = 0;

  race_official_multi #(.N_LANES(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .lane_en(lane_en), .ready(ready), .done(done),
    .start(start), .busy(busy), .finished(finished), .winner(winner),
    .winner_valid(winner_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] en, rd, dn;
    logic       st, bz;
    logic [3:0] fin;
    logic [1:0] win;
    logic       wv, to;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] en, rd, dn, input logic st, bz,
                              input logic [3:0] fin, input logic [1:0] win,
                              input logic wv, to);
    vec_t v;
    v.en = en; v.rd = rd; v.dn = dn; v.st = st; v.bz = bz;
    v.fin = fin; v.win = win; v.wv = wv; v.to = to;
    return v;
  endfunction

  // Reference model: each lane's finish time since start; winner = earliest.
  logic       m_racing, m_draining, m_to;
  logic [3:0] m_en;
  int         m_elapsed;
  int         m_fin_t[N];
  logic [1:0] m_win;

  function automatic void model_reset();
    m_racing = 0; m_draining = 0; m_to = 0; m_en = '0; m_elapsed = 0; m_win = '0;
    for (int i = 0; i < N; i++) m_fin_t[i] = -1;
  endfunction

  function automatic logic [3:0] model_fin();
    logic [3:0] f = '0;
    for (int i = 0; i < N; i++) f[i] = (m_fin_t[i] >= 0);
    return f;
  endfunction

  function automatic void model_step(input logic [3:0] en, rd, dn);
    int  best;
    bit  all;
    if (m_racing) begin
      for (int i = 0; i < N; i++)
        if (m_en[i] && dn[i] && m_fin_t[i] < 0) m_fin_t[i] = m_elapsed;
      best = -1;
      for (int i = 0; i < N; i++)
        if (m_fin_t[i] >= 0 && (best < 0 || m_fin_t[i] < m_fin_t[best])) best = i;
      if (best >= 0) m_win = 2'(best);
      all = 1;
      for (int i = 0; i < N; i++) if (m_en[i] && m_fin_t[i] < 0) all = 0;
      m_elapsed++;
      if (all) begin
        m_racing = 0; m_draining = 1;
      end else if (m_elapsed == TO) begin
        m_racing = 0; m_draining = 1; m_to = 1;
      end
    end else if (m_draining) begin
      if (((rd | dn) & m_en) == 4'h0) m_draining = 0;
    end else if (en != 4'h0 && (rd & en) == en) begin
      m_racing = 1; m_en = en; m_elapsed = 0; m_to = 0;
      for (int i = 0; i < N; i++) m_fin_t[i] = -1;
    end
  endfunction

  task automatic check(input string nm, input logic st, bz, input logic [3:0] fin,
                       input logic [1:0] win, input logic wv, to);
    n_vec++;
    if ({start, busy, finished, winner, winner_valid, timeout} !== {st, bz, fin, win, wv, to}) begin
      n_err++;
      $display("FAIL %s: got st=%0b bz=%0b fin=%h win=%0d wv=%0b to=%0b, expected st=%0b bz=%0b fin=%h win=%0d wv=%0b to=%0b",
               nm, start, busy, finished, winner, winner_valid, timeout, st, bz, fin, win, wv, to);
    end else begin
      $display("ok %s: st=%0b bz=%0b fin=%h win=%0d wv=%0b to=%0b",
               nm, start, busy, finished, winner, winner_valid, timeout);
    end
  endtask

  task automatic tick(input logic [3:0] en, rd, dn);
    lane_en = en; ready = rd; done = dn;
    @(posedge clk);
    model_step(en, rd, dn);
    #1;
  endtask

  task automatic check_model(input string nm);
    check(nm, m_racing, m_racing | m_draining, model_fin(), m_win, |model_fin(), m_to);
  endtask

  vec_t tbl[$];

  initial begin
    logic [3:0] r_en, r_rd, r_dn;

    // Directed table: basic race, tie, partial enable, timeout, lane_en=0.
    tbl.push_back(mk(4'hF, 4'hF, 4'h0, 1, 1, 4'h0, 0, 0, 0));
    tbl.push_back(mk(4'hF, 4'hF, 4'h4, 1, 1, 4'h4, 2, 1, 0));
    tbl.push_back(mk(4'hF, 4'hF, 4'h5, 1, 1, 4'h5, 2, 1, 0));
    tbl.push_back(mk(4'hF, 4'hF, 4'hD, 1, 1, 4'hD, 2, 1, 0));
    tbl.push_back(mk(4'hF, 4'hF, 4'hF, 0, 1, 4'hF, 2, 1, 0));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 0, 0, 4'hF, 2, 1, 0));
    tbl.push_back(mk(4'hF, 4'hF, 4'h0, 1, 1, 4'h0, 2, 0, 0));
    tbl.push_back(mk(4'hF, 4'hF, 4'hA, 1, 1, 4'hA, 1, 1, 0));
    tbl.push_back(mk(4'hF, 4'hF, 4'hF, 0, 1, 4'hF, 1, 1, 0));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 0, 0, 4'hF, 1, 1, 0));
    tbl.push_back(mk(4'h5, 4'h5, 4'h0, 1, 1, 4'h0, 1, 0, 0));
    tbl.push_back(mk(4'h5, 4'h5, 4'h2, 1, 1, 4'h0, 1, 0, 0));
    tbl.push_back(mk(4'h5, 4'h5, 4'h7, 0, 1, 4'h5, 0, 1, 0));
    tbl.push_back(mk(4'h5, 4'h0, 4'h0, 0, 0, 4'h5, 0, 1, 0));
    tbl.push_back(mk(4'hF, 4'hF, 4'h0, 1, 1, 4'h0, 0, 0, 0));
    for (int k = 0; k < TO - 1; k++)
      tbl.push_back(mk(4'hF, 4'hF, 4'h8, 1, 1, 4'h8, 3, 1, 0));
    tbl.push_back(mk(4'hF, 4'hF, 4'h8, 0, 1, 4'h8, 3, 1, 1));
    tbl.push_back(mk(4'hF, 4'hF, 4'h0, 0, 1, 4'h8, 3, 1, 1));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 0, 0, 4'h8, 3, 1, 1));
    tbl.push_back(mk(4'hF, 4'hF, 4'h0, 1, 1, 4'h0, 3, 0, 0));
    tbl.push_back(mk(4'hF, 4'h0, 4'hF, 0, 1, 4'hF, 0, 1, 0));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 0, 0, 4'hF, 0, 1, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(4'h0, 4'hF, 4'h0, 0, 0, 4'hF, 0, 1, 0));

    rst = 1'b1; lane_en = '0; ready = '0; done = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", 0, 0, 4'h0, 0, 0, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      tick(tbl[i].en, tbl[i].rd, tbl[i].dn);
      check($sformatf("tbl[%0d]", i), tbl[i].st, tbl[i].bz, tbl[i].fin,
            tbl[i].win, tbl[i].wv, tbl[i].to);
    end

    // Asynchronous reset mid-race, then re-arm from a held ready.
    tick(4'hF, 4'hF, 4'h0);
    tick(4'hF, 4'hF, 4'h1);
    check("race_before_rst", 1, 1, 4'h1, 0, 1, 0);
    rst = 1'b1;
    #1;
    check("rst_async", 0, 0, 4'h0, 0, 0, 0);
    #1;
    rst = 1'b0;
    model_reset();
    tick(4'hF, 4'hF, 4'h0);
    check("rearm_after_rst", 1, 1, 4'h0, 0, 0, 0);
    tick(4'hF, 4'h0, 4'h6);
    check("race_after_rst", 1, 1, 4'h6, 1, 1, 0);
    tick(4'hF, 4'h0, 4'h0);
    tick(4'hF, 4'h0, 4'h0);

    // Randomized traffic against the reference model.
    model_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick(4'h0, 4'h0, 4'h0);
    check_model("rnd_init");
    r_en = 4'hF;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) r_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 2) begin
        r_rd = '0; r_dn = '0;
      end else begin
        r_rd = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) r_rd = r_rd | r_en;
        r_dn = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      end
      tick(r_en, r_rd, r_dn);
      check_model($sformatf("rnd[%0d]", c));
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_model($sformatf("rnd_rst[%0d]", c));
        rst = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/race_official_multi.md
# race_official_multi

Parametrised multi-lane race official: a start/done handshake controller for up to N_LANES racers. It broadcasts a single `start` once every enabled lane reports ready, records which lanes have finished, and identifies the winner with lowest-index tie-break. It aborts the race on a programmable timeout and waits for all lanes to release before re-arming. It sits between the lane controllers and the scoreboard/display logic in the handshaking subsystem.

## Interface
- N_LANES, 4, number of racer lanes (1..16)
- TIMEOUT, 1000, max RACE-state cycles before abort; 0 disables timeout
- WIN_W, derived, winner index width = max(1, $clog2(N_LANES))
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high; all state and outputs cleared immediately
- lane_en  input  N_LANES  lanes taking part; sampled into `en_q` on IDLE->RACE
- ready  input  N_LANES  per-lane ready level
- done  input  N_LANES  per-lane done level
- start  output  1  registered broadcast start
- busy  output  1  high in RACE or RELEASE
- finished  output  N_LANES  lanes whose done has been seen this race (masked by en_q)
- winner  output  WIN_W  index of first finisher
- winner_valid  output  1  winner holds a valid index
- timeout  output  1  race aborted by timer

## Operation
- Reset values: state=IDLE, start=0, busy=0, finished=0, winner=0, winner_valid=0, timeout=0, en_q=0, timer=0.
- States: IDLE(0), RACE(1), RELEASE(2); unused encoding (3) -> IDLE with start=0 on the next edge.
- IDLE: start=0. Leave when lane_en!=0 and (ready & lane_en)==lane_en. On that edge: en_q<=lane_en, start<=1, timer<=0, finished<=0, winner_valid<=0, timeout<=0, state<=RACE. If lane_en==0, stay in IDLE.
- RACE: start=1, timer increments each cycle (saturating). nd = done & en_q & ~finished.
  - finished <= finished | nd.
  - If winner_valid==0 and nd!=0: winner<=lowest set index of nd, winner_valid<=1. Simultaneous finishers go to the lowest index.
  - All done: if (finished|nd)==en_q -> start<=0, state<=RELEASE. This takes priority over timeout in the same cycle.
  - Timeout: else if TIMEOUT!=0 and timer==TIMEOUT-1 -> start<=0, timeout<=1, state<=RELEASE.
  - Ready dropping in RACE is ignored.
  - done on lanes not in en_q is ignored for the whole race.
- RELEASE: start=0. Leave to IDLE when (ready|done) & en_q == 0.
- finished, winner, winner_valid and timeout hold through RELEASE and IDLE. They clear only on the next IDLE->RACE edge.
- busy = (state != IDLE), decoded from the state register.
- Arithmetic:
  - timer width = max(1, $clog2(TIMEOUT+1)); it never wraps.
  - Priority encode of nd is combinational, lowest index wins.

## Timing
- start rises on the edge that samples the full ready condition, one cycle after ready completes.
- winner/winner_valid update on the same edge that first samples done; finished updates in the same cycle.
- start falls on the edge that samples the last enabled done, i.e. one cycle after it.
- Timeout: start falls exactly TIMEOUT clocks after start rose. timeout=1 from that edge onward.
- Minimum back-to-back race spacing:
  - RELEASE needs ≥1 cycle with ready and done low.
  - IDLE needs ≥1 cycle before start can rise again.
- rst asserted mid-race: start drops asynchronously and outputs clear. After deassertion the FSM is in IDLE and re-arms only on a fresh ready condition.
- Inputs are synchronous to clk; no internal synchronisers.

## Test plan
- Basic race, N_LANES=4, lane_en=4'hF:
  - ready=4'hF at cycle 0 -> start=1 at cycle 1.
  - done lanes 2,0,3,1 in successive cycles -> winner=2, winner_valid=1 after the first edge; finished builds up to 4'hF; start=0 one edge after lane 1 done.
  - All inputs released -> back in IDLE after 1 cycle.
- Tie: done=4'b1010 in the same cycle -> winner=1, finished=4'b1010.
- Partial enable: lane_en=4'b0101, ready=4'b0101 -> start=1. done on lane 1 -> ignored. done lanes 0 and 2 -> RELEASE, winner=0.
- Timeout, TIMEOUT=8:
  - Only lane 3 finishes -> start high exactly 8 cycles; timeout=1; finished=4'b1000; winner=3.
  - Holding ready high in RELEASE keeps the FSM there; dropping it -> IDLE.
  - Next race start clears timeout and winner_valid.
- Reset mid-race: assert rst while start=1 -> start=0 and busy=0 immediately, before the next clk edge, with all outputs at reset values. After release with ready still high -> start reasserts one cycle later.
- lane_en=0 with ready=4'hF -> start stays 0 and busy stays 0 indefinitely.
